div_unit: RTL

Sequential 32-bit signed integer divider for the execute stage, alongside the ALU and its shifter. It computes one quotient bit per clock using shift-and-subtract (restoring) iteration. Operands arrive from the execute-stage operand muxes; the quotient goes to the writeback result mux. A one-cycle ready strobe stalls and releases the pipeline.

---
 rtl/div_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Sequential 32-bit signed restoring divider: one quotient bit per clock, one-cycle ready strobe.
// Optional macro DIV_REMAINDER_EN adds the signed data_remainder output.
module div_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
`ifdef DIV_REMAINDER_EN
   ,
   output logic [31:0] data_remainder
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] q;
   logic [32:0] d;
   logic [32:0] r;
   logic [5:0]  counter;
   logic        sign_q;
   logic        zero;
`ifdef DIV_REMAINDER_EN
   logic        sign_r;
   logic [31:0] rem_fin;
`endif

   logic [31:0] a_abs;
   logic [31:0] b_abs;
   logic [33:0] r_sh;
   logic [33:0] t;
   logic [31:0] q_next;
   logic [32:0] r_next;
   logic [31:0] q_fin;
   logic        last_step;

   always_comb begin
      a_abs     = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
      b_abs     = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
      // R never exceeds 2^32-1 after a shift, so a 34-bit difference keeps the sign bit honest.
      r_sh      = {r, q[31]};
      t         = r_sh - {1'b0, d};
      q_next    = {q[30:0], ~t[33]};
      r_next    = t[33] ? r_sh[32:0] : t[32:0];
      q_fin     = sign_q ? (32'd0 - q_next) : q_next;
      last_step = (state == BUSY) && (counter == 6'd31);
`ifdef DIV_REMAINDER_EN
      rem_fin   = sign_r ? (32'd0 - r_next[31:0]) : r_next[31:0];
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (ctrl_DIV) begin
         state_next = BUSY;
      end else begin
         case (state)
            IDLE:    state_next = IDLE;
            BUSY:    state_next = last_step ? DONE : BUSY;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q              <= 32'd0;
         d              <= 33'd0;
         r              <= 33'd0;
         counter        <= 6'd0;
         sign_q         <= 1'b0;
         zero           <= 1'b0;
         data_result    <= 32'd0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
         sign_r         <= 1'b0;
         data_remainder <= 32'd0;
`endif
      end else begin
         data_resultRDY <= 1'b0;
         if (ctrl_DIV) begin
            // A start in any state, including mid-iteration, abandons whatever was in flight.
            q              <= a_abs;
            d              <= {1'b0, b_abs};
            r              <= 33'd0;
            counter        <= 6'd0;
            sign_q         <= data_operandA[31] ^ data_operandB[31];
            zero           <= (data_operandB == 32'd0);
            data_result    <= 32'd0;
            data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
            sign_r         <= data_operandA[31];
            data_remainder <= 32'd0;
`endif
         end else if (state == BUSY) begin
            q       <= q_next;
            r       <= r_next;
            counter <= counter + 6'd1;
            if (last_step) begin
               data_result    <= zero ? 32'd0 : q_fin;
               data_exception <= zero;
               data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
               data_remainder <= zero ? 32'd0 : rem_fin;
`endif
            end
         end
      end
   end

endmodule
